kodd_dmem: RTL and testbench
============================

Name: kodd_dmem

Overview:
- Data-memory responder on the core's M-stage port: serves scalar loads/stores (ALUOutM/WriteDataM/ReadDataM) and 4-lane vector loads/stores (VectorAddressM/WriteDataMVec/ReadDataVecM).
- Word array has 5 asynchronous read ports (1 scalar, 4 vector) and a single synchronous write port.
- A vector store is serialized over 4 cycles by an FSM; StallM tells hazard logic to hold the M stage.

Parameters:
- DEPTH, 256, number of 32-bit words; must be a power of two >= 4.
- AW, $clog2(DEPTH), word-index width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- MemWriteM  input  1  scalar store request.
- MemWriteVecM  input  1  vector store request.
- ALUOutM  input  32  scalar byte address.
- WriteDataM  input  32  scalar store data.
- VectorAddressM[0:3]  input  32 each  per-lane byte address.
- WriteDataMVec[0:3]  input  32 each  per-lane store data.
- ReadDataM  output  32  scalar load data.
- ReadDataVecM[0:3]  output  32 each  per-lane load data.
- StallM  output  1  hold the M stage; combinational.
- ErrM  output  1  sticky error flag.
- WrCount  output  16  committed word writes, saturating.

Behaviour:
- Addressing: word index = addr[AW+1:2]. addr[1:0] is ignored. Upper bits wrap unless the optional feature is enabled.
- Reads: combinational from the array, zero latency. ReadDataM and all ReadDataVecM lanes are forced to 0 while reset is low. Array contents are not reset.
- FSM states: IDLE, VWR. Lane counter LANE is 2 bits. Snapshot registers hold addresses and data for lanes 1..3.
- IDLE, MemWriteVecM=1:
  - Write lane 0 at this edge.
  - Capture lanes 1..3 into the snapshot.
  - LANE<=1, go to VWR.
  - StallM=1 combinationally in this cycle.
- IDLE, MemWriteM=1 only: write at this edge. StallM=0, single cycle.
- IDLE, MemWriteM and MemWriteVecM both 1: the vector store wins, the scalar store is dropped, ErrM<=1.
- VWR:
  - Each cycle, write the snapshot lane LANE and increment LANE.
  - StallM=1 while LANE is 1 or 2. StallM=0 in the LANE=3 cycle, so the core advances at that edge.
  - After the lane-3 edge, return to IDLE.
- Vector store occupancy is 4 cycles; StallM is high for 3 of them.
- While in VWR, all request inputs are ignored; the core holds the same instruction. The snapshot, not the live inputs, is written.
- Duplicate lane addresses: lanes commit in order 0..3, so the higher lane wins.
- Read during VWR: returns the array as currently written, i.e. lanes already committed are visible and pending lanes are not.
- WrCount: increments by 1 per committed word write and saturates at 16'hFFFF. Dropped writes do not count.
- Reset low mid-VWR: FSM goes to IDLE, LANE<=0, and uncommitted lanes are discarded. Already-written lanes remain in the array.
- Reset values: StallM=0, ErrM=0, WrCount=0, LANE=0, snapshot=0, state=IDLE.
- ErrM clears only on reset.

Optional Feature:
- Macro: KODD_DMEM_BOUNDS_EN.
- Enabled:
  - Any access with addr[31:AW+2] != 0 is out of range.
  - Out-of-range writes, scalar or per lane, are suppressed, not counted, and set ErrM.
  - Out-of-range reads return 32'hDEADBEEF on that port and do not set ErrM.
  - A vector store with some lanes out of range still takes the full 4 cycles; only the valid lanes commit.
- Disabled: addresses wrap modulo DEPTH; no bounds error source exists.

Test Plan:
- Reset, then scalar store MemWriteM=1, ALUOutM=0x10, WriteDataM=0xA5A5A5A5 -> next cycle ReadDataM=0xA5A5A5A5 at 0x10; StallM never high; WrCount=1.
- Vector store to addresses 0x20/0x24/0x28/0x2C with data 1/2/3/4 -> StallM high exactly 3 cycles; at the end, ReadDataVecM reads back 1,2,3,4; WrCount=4.
- Vector store with all four lanes at address 0x40, data 5/6/7/8 -> a read of 0x40 returns 8; WrCount=4.
- MemWriteM and MemWriteVecM high together (scalar to 0x50=0xFF, vector to 0x60..0x6C) -> 0x50 unchanged, vector lanes written, ErrM=1.
- Reset pulsed low during the LANE=2 cycle of a vector store to 0x80..0x8C -> lanes 0 and 1 present, lanes 2 and 3 unchanged; StallM=0, WrCount=0, ErrM=0 after reset.
- With KODD_DMEM_BOUNDS_EN, DEPTH=256: scalar store to 0x400 -> no write, ErrM=1; read of 0x400 -> 0xDEADBEEF. Without the macro, the same store lands at word 0.

Source files
------------

// File: rtl/kodd_dmem.sv
// kodd_dmem -- M-stage data memory responder.
//
// Serves scalar loads/stores and 4-lane vector loads/stores from one word
// array with five asynchronous read ports and a single synchronous write
// port. A vector store occupies the write port for four cycles: lane 0 is
// written on the request edge, and lanes 1..3 are replayed from a snapshot
// over the next three edges. StallM holds the M stage until the last lane.
//
// Optional build macro: KODD_DMEM_BOUNDS_EN
//   defined   : any address with bits above the word index set is out of
//               range; writes there are suppressed and set ErrM, and reads
//               there return 32'hDEADBEEF.
//   undefined : addresses wrap modulo DEPTH.
//
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous active-low reset
//   MemWriteM      scalar store request
//   MemWriteVecM   vector store request
//   ALUOutM        scalar byte address
//   WriteDataM     scalar store data
//   VectorAddressM per-lane byte addresses, lane i = VectorAddressM[i]
//   WriteDataMVec  per-lane store data
//   ReadDataM      scalar load data (combinational)
//   ReadDataVecM   per-lane load data (combinational)
//   StallM         hold the M stage (combinational)
//   ErrM           sticky error flag, cleared only by reset
//   WrCount        committed word writes, saturating at 16'hFFFF

// Address decoder: byte address -> word index plus out-of-range flag.
module kodd_dmem_addr #(
  parameter int AW = 8
) (
  input  logic [31:0]   addr,
  output logic [AW-1:0] idx,
  output logic          oor
);
  // Byte-offset bits (and, when wrapping, the upper bits) are dropped on
  // purpose; they are folded here only so the intent is explicit.
  logic unusedBits;

  assign idx = addr[AW+1:2];

`ifdef KODD_DMEM_BOUNDS_EN
  assign oor        = |addr[31:AW+2];
  assign unusedBits = ^addr[1:0];
`else
  assign oor        = 1'b0;
  assign unusedBits = ^{addr[1:0], addr[31:AW+2]};
`endif
endmodule

module kodd_dmem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemWriteM,
  input  logic                  MemWriteVecM,
  input  logic [31:0]           ALUOutM,
  input  logic [31:0]           WriteDataM,
  input  logic [3:0][31:0]      VectorAddressM,
  input  logic [3:0][31:0]      WriteDataMVec,
  output logic [31:0]           ReadDataM,
  output logic [3:0][31:0]      ReadDataVecM,
  output logic                  StallM,
  output logic                  ErrM,
  output logic [15:0]           WrCount
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 32;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] VWR  = 1'b1;

  localparam logic [VEC_W-1:0] OOR_DATA = 32'hDEADBEEF;

  logic [VEC_W-1:0] mem [DEPTH];

  logic [0:0] state;
  logic [1:0] lane;

  // Snapshot of lanes 1..3, stored already decoded. Element 0 exists only
  // so the live lane counter can index the array directly; it stays zero.
  logic [NUM_LANES-1:0][AW-1:0]    snapIdx;
  logic [NUM_LANES-1:0]            snapOor;
  logic [NUM_LANES-1:0][VEC_W-1:0] snapData;

  logic [AW-1:0]                sIdx;
  logic                         sOor;
  logic [NUM_LANES-1:0][AW-1:0] vIdx;
  logic [NUM_LANES-1:0]         vOor;

  logic             wrEn;
  logic             wrOor;
  logic [AW-1:0]    wrIdx;
  logic [VEC_W-1:0] wrData;
  logic             wrCommit;
  logic             errSet;

  // ---------------------------------------------------------------------
  // Address decode and read ports
  // ---------------------------------------------------------------------
  kodd_dmem_addr #(.AW(AW)) uDecS (
    .addr (ALUOutM),
    .idx  (sIdx),
    .oor  (sOor)
  );

  assign ReadDataM = !reset ? '0 : (sOor ? OOR_DATA : mem[sIdx]);

  for (genvar g = 0; g < NUM_LANES; g++) begin : gLane
    kodd_dmem_addr #(.AW(AW)) uDecV (
      .addr (VectorAddressM[g]),
      .idx  (vIdx[g]),
      .oor  (vOor[g])
    );

    assign ReadDataVecM[g] = !reset ? '0 : (vOor[g] ? OOR_DATA : mem[vIdx[g]]);
  end

  // ---------------------------------------------------------------------
  // Write port select. In VWR the snapshot owns the port and live
  // requests are ignored; in IDLE a vector request beats a scalar one.
  // ---------------------------------------------------------------------
  always_comb begin
    wrEn   = 1'b0;
    wrOor  = 1'b0;
    wrIdx  = '0;
    wrData = '0;
    if (state == VWR) begin
      wrEn   = 1'b1;
      wrOor  = snapOor[lane];
      wrIdx  = snapIdx[lane];
      wrData = snapData[lane];
    end else if (MemWriteVecM) begin
      wrEn   = 1'b1;
      wrOor  = vOor[0];
      wrIdx  = vIdx[0];
      wrData = WriteDataMVec[0];
    end else if (MemWriteM) begin
      wrEn   = 1'b1;
      wrOor  = sOor;
      wrIdx  = sIdx;
      wrData = WriteDataM;
    end
    // The array has no reset, so block writes while reset is held.
    if (!reset) wrEn = 1'b0;
  end

  assign wrCommit = wrEn & ~wrOor;

  // Dropped scalar (collision) or suppressed out-of-range write.
  assign errSet = reset &
                  (((state == IDLE) & MemWriteVecM & MemWriteM) | (wrEn & wrOor));

  // Stall through the request cycle and lanes 1..2; the lane-3 cycle
  // releases the core so it advances on the final commit edge.
  assign StallM = reset &
                  (((state == IDLE) & MemWriteVecM) |
                   ((state == VWR) & (lane != 2'd3)));

  always_ff @(posedge clk) begin
    if (wrCommit) mem[wrIdx] <= wrData;
  end

  // ---------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      lane     <= '0;
      snapIdx  <= '0;
      snapOor  <= '0;
      snapData <= '0;
      ErrM     <= 1'b0;
      WrCount  <= '0;
    end else begin
      if (errSet) ErrM <= 1'b1;
      if (wrCommit && (WrCount != 16'hFFFF)) WrCount <= WrCount + 16'd1;

      case (state)
        IDLE: begin
          if (MemWriteVecM) begin
            for (int i = 1; i < NUM_LANES; i++) begin
              snapIdx[i]  <= vIdx[i];
              snapOor[i]  <= vOor[i];
              snapData[i] <= WriteDataMVec[i];
            end
            lane  <= 2'd1;
            state <= VWR;
          end
        end
        VWR: begin
          // 3 + 1 wraps the counter back to 0 as we leave.
          lane <= lane + 2'd1;
          if (lane == 2'd3) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          lane  <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_kodd_dmem.sv
module tb_kodd_dmem;
  logic             clk;
  logic             reset;
  logic             MemWriteM;
  logic             MemWriteVecM;
  logic [31:0]      ALUOutM;
  logic [31:0]      WriteDataM;
  logic [3:0][31:0] VectorAddressM;
  logic [3:0][31:0] WriteDataMVec;
  logic [31:0]      ReadDataM;
  logic [3:0][31:0] ReadDataVecM;
  logic             StallM;
  logic             ErrM;
  logic [15:0]      WrCount;

  int nChecks = 0;
  int nPass   = 0;

  kodd_dmem #(.DEPTH(256)) dut (
    .clk            (clk),
    .reset          (reset),
    .MemWriteM      (MemWriteM),
    .MemWriteVecM   (MemWriteVecM),
    .ALUOutM        (ALUOutM),
    .WriteDataM     (WriteDataM),
    .VectorAddressM (VectorAddressM),
    .WriteDataMVec  (WriteDataMVec),
    .ReadDataM      (ReadDataM),
    .ReadDataVecM   (ReadDataVecM),
    .StallM         (StallM),
    .ErrM           (ErrM),
    .WrCount        (WrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic             wr;
    logic             vec;
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [3:0][31:0] vaddr;
    logic [3:0][31:0] vdata;
    logic [31:0]      expS;
    logic [3:0][31:0] expV;
    logic [15:0]      expCnt;
    int               expStall;
    logic             expErr;
  } rec_t;

  rec_t tbl[5];

  function automatic logic [3:0][31:0] lanes(input logic [31:0] a0, a1, a2, a3);
    logic [3:0][31:0] r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chkLanes(input string nm, input logic [3:0][31:0] exp);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s lane%0d", nm, i), ReadDataVecM[i], exp[i]);
  endtask

  // Drive a request and hold it until the edge at which StallM is low,
  // counting stall cycles on the way. Returns at posedge+1 with requests off
  // but addresses still applied, so readback follows immediately.
  task automatic doOp(input rec_t r, output int stalls);
    bit done;
    stalls = 0;
    done   = 0;
    MemWriteM      = r.wr;
    MemWriteVecM   = r.vec;
    ALUOutM        = r.addr;
    WriteDataM     = r.data;
    VectorAddressM = r.vaddr;
    WriteDataMVec  = r.vdata;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge clk);
      if (StallM) stalls++;
      else done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      nChecks++;
      $display("FAIL %s: StallM never released within 8 cycles", r.name);
    end
    MemWriteM    = 1'b0;
    MemWriteVecM = 1'b0;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic scalarWr(input logic [31:0] a, input logic [31:0] d);
    rec_t r;
    int   s;
    r.name = "prewrite"; r.wr = 1'b1; r.vec = 1'b0; r.addr = a; r.data = d;
    r.vaddr = '0; r.vdata = '0;
    doOp(r, s);
  endtask

  initial begin
    rec_t r;
    int   stalls;

    // --- vector table (cumulative state, one reset at the start) -------
    tbl[0] = '{"scalar 0x10", 1'b1, 1'b0, 32'h10, 32'hA5A5A5A5,
               lanes(32'h10, 32'h10, 32'h10, 32'h10), '0,
               32'hA5A5A5A5, lanes(32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5),
               16'd1, 0, 1'b0};
    tbl[1] = '{"vector 0x20", 1'b0, 1'b1, 32'h10, 32'h0,
               lanes(32'h20, 32'h24, 32'h28, 32'h2C), lanes(32'd1, 32'd2, 32'd3, 32'd4),
               32'hA5A5A5A5, lanes(32'd1, 32'd2, 32'd3, 32'd4),
               16'd5, 3, 1'b0};
    tbl[2] = '{"vector dup 0x40", 1'b0, 1'b1, 32'h40, 32'h0,
               lanes(32'h40, 32'h40, 32'h40, 32'h40), lanes(32'd5, 32'd6, 32'd7, 32'd8),
               32'd8, lanes(32'd8, 32'd8, 32'd8, 32'd8),
               16'd9, 3, 1'b0};
    tbl[3] = '{"scalar byte-offset", 1'b1, 1'b0, 32'h47, 32'h12345678,
               lanes(32'h44, 32'h45, 32'h46, 32'h47), '0,
               32'h12345678, lanes(32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678),
               16'd10, 0, 1'b0};
`ifdef KODD_DMEM_BOUNDS_EN
    tbl[4] = '{"scalar 0x400", 1'b1, 1'b0, 32'h400, 32'hCAFEF00D,
               lanes(32'h10, 32'h20, 32'h2C, 32'h400), '0,
               32'hDEADBEEF, lanes(32'hA5A5A5A5, 32'd1, 32'd4, 32'hDEADBEEF),
               16'd10, 0, 1'b1};
`else
    tbl[4] = '{"scalar 0x400", 1'b1, 1'b0, 32'h400, 32'hCAFEF00D,
               lanes(32'h10, 32'h20, 32'h2C, 32'h400), '0,
               32'hCAFEF00D, lanes(32'hA5A5A5A5, 32'd1, 32'd4, 32'hCAFEF00D),
               16'd11, 0, 1'b0};
`endif

    // --- reset state ---------------------------------------------------
    reset = 1'b0; MemWriteM = 1'b0; MemWriteVecM = 1'b1;
    ALUOutM = '0; WriteDataM = '0; VectorAddressM = '0; WriteDataMVec = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset StallM", {31'd0, StallM}, 32'd0);
    chk("reset ErrM", {31'd0, ErrM}, 32'd0);
    chk("reset WrCount", {16'd0, WrCount}, 32'd0);
    chk("reset ReadDataM", ReadDataM, 32'd0);
    chkLanes("reset ReadDataVecM", '0);
    MemWriteVecM = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // --- table-driven part ---------------------------------------------
    foreach (tbl[k]) begin
      doOp(tbl[k], stalls);
      #1;
      chk({tbl[k].name, " stalls"}, stalls, tbl[k].expStall);
      chk({tbl[k].name, " ReadDataM"}, ReadDataM, tbl[k].expS);
      chkLanes({tbl[k].name, " ReadDataVecM"}, tbl[k].expV);
      chk({tbl[k].name, " WrCount"}, {16'd0, WrCount}, {16'd0, tbl[k].expCnt});
      chk({tbl[k].name, " ErrM"}, {31'd0, ErrM}, {31'd0, tbl[k].expErr});
    end

    // --- scalar and vector requested together ---------------------------
    pulseReset();
    chk("collide pre ErrM", {31'd0, ErrM}, 32'd0);
    scalarWr(32'h50, 32'h11);
    r.name = "collide"; r.wr = 1'b1; r.vec = 1'b1; r.addr = 32'h50; r.data = 32'hFF;
    r.vaddr = lanes(32'h60, 32'h64, 32'h68, 32'h6C);
    r.vdata = lanes(32'h61, 32'h62, 32'h63, 32'h64);
    doOp(r, stalls);
    #1;
    chk("collide stalls", stalls, 3);
    chk("collide scalar dropped", ReadDataM, 32'h11);
    chkLanes("collide lanes", lanes(32'h61, 32'h62, 32'h63, 32'h64));
    chk("collide ErrM", {31'd0, ErrM}, 32'd1);
    chk("collide WrCount", {16'd0, WrCount}, 32'd5);

    // --- reset during the LANE=2 cycle -----------------------------------
    pulseReset();
    scalarWr(32'h88, 32'hAAAA0002);
    scalarWr(32'h8C, 32'hAAAA0003);
    MemWriteVecM   = 1'b1;
    ALUOutM        = 32'h80;
    VectorAddressM = lanes(32'h80, 32'h84, 32'h88, 32'h8C);
    WriteDataMVec  = lanes(32'hB0, 32'hB1, 32'hB2, 32'hB3);
    @(posedge clk); #1;   // lane 0 committed, now LANE=1
    @(posedge clk); #1;   // lane 1 committed, now LANE=2
    chk("midVWR StallM", {31'd0, StallM}, 32'd1);
    chkLanes("midVWR visible", lanes(32'hB0, 32'hB1, 32'hAAAA0002, 32'hAAAA0003));
    reset = 1'b0;
    #1;
    chk("midVWR rst StallM", {31'd0, StallM}, 32'd0);
    chk("midVWR rst WrCount", {16'd0, WrCount}, 32'd0);
    chk("midVWR rst ErrM", {31'd0, ErrM}, 32'd0);
    chk("midVWR rst ReadDataM", ReadDataM, 32'd0);
    @(negedge clk);
    MemWriteVecM = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midVWR post StallM", {31'd0, StallM}, 32'd0);
    chk("midVWR post WrCount", {16'd0, WrCount}, 32'd0);
    chk("midVWR post ReadDataM", ReadDataM, 32'hB0);
    chkLanes("midVWR post lanes", lanes(32'hB0, 32'hB1, 32'hAAAA0002, 32'hAAAA0003));

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
